async_fifo_lvl: RTL and testbench
=================================

Name: async_fifo_lvl

Overview:
- Parametrised dual-clock FIFO; successor to the basic Gray-pointer asynchronous FIFO.
- Adds the following per-domain features:
  - Registered fill-level counters.
  - Programmable almost-full / almost-empty flags.
  - Sticky overflow / underflow error flags with clear inputs.
- Sits between a write-clock producer and a read-clock consumer.
- Storage is a DEPTH = 2**ADDRSIZE entry register array. Read data is first-word-fall-through.

Parameters:
- DATASIZE, 8, data word width in bits.
- ADDRSIZE, 4, address width; DEPTH = 2**ADDRSIZE; minimum 2.

Ports:
- wclk  in  1  write-domain clock.
- wrst_n  in  1  write-domain reset, asynchronous, active-low.
- rclk  in  1  read-domain clock.
- rrst_n  in  1  read-domain reset, asynchronous, active-low.
- winc  in  1  write request.
- wdata  in  DATASIZE  write data.
- afull_lvl  in  ADDRSIZE+1  almost-full threshold; quasi-static.
- wclr_ovf  in  1  clears woverflow.
- wfull  out  1  FIFO full.
- wafull  out  1  almost full.
- wlevel  out  ADDRSIZE+1  write-side fill level, 0..DEPTH.
- woverflow  out  1  sticky: write attempted while full.
- rinc  in  1  read request / pop.
- aempty_lvl  in  ADDRSIZE+1  almost-empty threshold; quasi-static.
- rclr_unf  in  1  clears runderflow.
- rdata  out  DATASIZE  head-of-FIFO data.
- rempty  out  1  FIFO empty.
- raempty  out  1  almost empty.
- rlevel  out  ADDRSIZE+1  read-side fill level.
- runderflow  out  1  sticky: read attempted while empty.

Behaviour:
- Pointers:
  - Binary and Gray pointers are ADDRSIZE+1 bits and reset to 0.
  - Write pointer increments when winc && !wfull; read pointer when rinc && !rempty.
  - Memory is addressed by the low ADDRSIZE binary bits. Wrap-around is natural modulo 2**(ADDRSIZE+1).
- Crossing: only registered Gray pointers cross domains, each through a 2-flop synchronizer reset by the destination domain's reset. No other signal crosses.
- Memory:
  - Written on the wclk edge when winc && !wfull.
  - rdata = mem[raddr], combinational (FWFT). It is valid whenever rempty=0.
- wfull: registered; set when the next write Gray pointer equals the synchronized read pointer with its two MSBs inverted.
- rempty: registered; set when the next read Gray pointer equals the synchronized write pointer.
- wlevel:
  - Registered each wclk: wbinnext - gray2bin(wq2_rptr), ADDRSIZE+1 bits, unsigned.
  - Never exceeds DEPTH. Pessimistic: may over-report while reads are in flight.
- rlevel:
  - Registered each rclk: gray2bin(rq2_wptr) - rbinnext.
  - Pessimistic: may under-report.
- wafull = registered (wlevel_next >= afull_lvl). afull_lvl=0 forces wafull=1.
- raempty = registered (rlevel_next <= aempty_lvl).
- wafull, wlevel, wfull update on the same wclk edge, consistent with each other. The read-side flags rempty, raempty, rlevel do the same on rclk.
- Overflow:
  - winc && wfull drops the write: no memory or pointer change.
  - woverflow is set on that wclk edge and holds until wclr_ovf.
  - Simultaneous set and clear: set wins.
- Underflow:
  - rinc && rempty: no pointer change.
  - runderflow is set on that rclk edge and holds until rclr_unf.
  - Simultaneous set and clear: set wins.
- Latency:
  - Write to rempty deassert: at most 3 rclk edges after the capturing wclk edge.
  - Read to wfull deassert: at most 3 wclk edges after the capturing rclk edge.
- Reset values, applied asynchronously:
  - wrst_n low: wfull=0, wafull=0, wlevel=0, woverflow=0, write pointers 0.
  - rrst_n low: rempty=1, raempty=1, rlevel=0, runderflow=0, read pointers 0.
- Reset mid-operation: both resets must be asserted together. Memory contents are not reset. Data in flight is discarded.

Test Plan:
1. Reset, DATASIZE=8, ADDRSIZE=4, aempty_lvl=2 -> wfull=0, wafull=0, wlevel=0, rempty=1, raempty=1, rlevel=0, both error flags 0.
2. Write 0x00..0x0F, rinc=0 -> wfull=1 and wlevel=16 on the 16th write edge. Then write 0xAA -> dropped and woverflow=1. Then read 16 -> rdata 0x00..0x0F in order, 0xAA never seen, rempty=1.
3. afull_lvl=12:
   - 12 writes -> wafull=1 on the 12th write edge.
   - 1 read -> wafull=0 within 3 wclk edges once rlevel/wlevel show 11.
   - aempty_lvl=2 -> raempty falls when rlevel reaches 3.
4. rinc=1 while empty -> runderflow=1, read pointer unchanged. Pulse rclr_unf -> runderflow=0. Repeat with rinc and rclr_unf together -> runderflow stays 1.
5. wclk 100 MHz, rclk 37 MHz, random winc/rinc, 200 words -> scoreboard in-order match, no pointer corruption across several wraps, wlevel never exceeds 16.
6. Fill to 9 words, then assert wrst_n and rrst_n mid-traffic -> all flags reset immediately. Post-reset write 0x5A -> first read returns 0x5A.

Source files
------------

// File: rtl/async_fifo_lvl_if.sv
// Bus bundle for async_fifo_lvl: write-side and read-side handshake, thresholds,
// fill levels and error flags. Clocks and resets stay as plain ports.
interface async_fifo_lvl_if #(
  parameter int DATASIZE = 8,
  parameter int ADDRSIZE = 4
);
  logic                winc;
  logic [DATASIZE-1:0] wdata;
  logic [ADDRSIZE:0]   afull_lvl;
  logic                wclr_ovf;
  logic                wfull;
  logic                wafull;
  logic [ADDRSIZE:0]   wlevel;
  logic                woverflow;

  logic                rinc;
  logic [ADDRSIZE:0]   aempty_lvl;
  logic                rclr_unf;
  logic [DATASIZE-1:0] rdata;
  logic                rempty;
  logic                raempty;
  logic [ADDRSIZE:0]   rlevel;
  logic                runderflow;

  modport master (
    output winc, wdata, afull_lvl, wclr_ovf, rinc, aempty_lvl, rclr_unf,
    input  wfull, wafull, wlevel, woverflow, rdata, rempty, raempty, rlevel, runderflow
  );

  modport slave (
    input  winc, wdata, afull_lvl, wclr_ovf, rinc, aempty_lvl, rclr_unf,
    output wfull, wafull, wlevel, woverflow, rdata, rempty, raempty, rlevel, runderflow
  );
endinterface

// File: rtl/async_fifo_lvl.sv
// Dual-clock Gray-pointer FIFO with registered fill levels, almost-full/empty
// thresholds and sticky overflow/underflow flags. Read data is first-word-fall-through.
module async_fifo_lvl #(
  parameter int DATASIZE = 8,
  parameter int ADDRSIZE = 4
) (
  input  logic            wclk,
  input  logic            wrst_n,
  input  logic            rclk,
  input  logic            rrst_n,
  async_fifo_lvl_if.slave bus
);
  localparam int DEPTH = 2 ** ADDRSIZE;

  typedef logic [ADDRSIZE:0] ptr_t;

  function automatic ptr_t bin2gray(input ptr_t b);
    return (b >> 1) ^ b;
  endfunction

  // Each binary bit is the XOR of all Gray bits at and above it.
  function automatic ptr_t gray2bin(input ptr_t g);
    ptr_t b;
    b = '0;
    for (int unsigned i = 0; i < ADDRSIZE + 1; i++) b[i] = ^(g >> i);
    return b;
  endfunction

  logic [DATASIZE-1:0] mem [DEPTH];

  ptr_t wbin, wptr, wq1_rptr, wq2_rptr;
  ptr_t wbin_next, wgray_next, wlevel_next;
  logic wpush, wfull_next;

  ptr_t rbin, rptr, rq1_wptr, rq2_wptr;
  ptr_t rbin_next, rgray_next, rlevel_next;
  logic rpop, rempty_next;

  // Write domain
  always_comb begin
    wpush       = bus.winc && !bus.wfull;
    wbin_next   = wbin + ptr_t'(wpush);
    wgray_next  = bin2gray(wbin_next);
    wfull_next  = (wgray_next == {~wq2_rptr[ADDRSIZE:ADDRSIZE-1], wq2_rptr[ADDRSIZE-2:0]});
    wlevel_next = wbin_next - gray2bin(wq2_rptr);
  end

  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      wbin          <= '0;
      wptr          <= '0;
      wq1_rptr      <= '0;
      wq2_rptr      <= '0;
      bus.wfull     <= 1'b0;
      bus.wafull    <= 1'b0;
      bus.wlevel    <= '0;
      bus.woverflow <= 1'b0;
    end else begin
      wbin       <= wbin_next;
      wptr       <= wgray_next;
      wq1_rptr   <= rptr;
      wq2_rptr   <= wq1_rptr;
      bus.wfull  <= wfull_next;
      bus.wlevel <= wlevel_next;
      bus.wafull <= (wlevel_next >= bus.afull_lvl);
      // Set has priority over clear.
      if (bus.winc && bus.wfull) bus.woverflow <= 1'b1;
      else if (bus.wclr_ovf)     bus.woverflow <= 1'b0;
    end
  end

  always_ff @(posedge wclk) begin
    if (wpush) mem[wbin[ADDRSIZE-1:0]] <= bus.wdata;
  end

  // Read domain
  always_comb begin
    rpop        = bus.rinc && !bus.rempty;
    rbin_next   = rbin + ptr_t'(rpop);
    rgray_next  = bin2gray(rbin_next);
    rempty_next = (rgray_next == rq2_wptr);
    rlevel_next = gray2bin(rq2_wptr) - rbin_next;
    bus.rdata   = mem[rbin[ADDRSIZE-1:0]];
  end

  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      rbin           <= '0;
      rptr           <= '0;
      rq1_wptr       <= '0;
      rq2_wptr       <= '0;
      bus.rempty     <= 1'b1;
      bus.raempty    <= 1'b1;
      bus.rlevel     <= '0;
      bus.runderflow <= 1'b0;
    end else begin
      rbin        <= rbin_next;
      rptr        <= rgray_next;
      rq1_wptr    <= wptr;
      rq2_wptr    <= rq1_wptr;
      bus.rempty  <= rempty_next;
      bus.rlevel  <= rlevel_next;
      bus.raempty <= (rlevel_next <= bus.aempty_lvl);
      if (bus.rinc && bus.rempty) bus.runderflow <= 1'b1;
      else if (bus.rclr_unf)      bus.runderflow <= 1'b0;
    end
  end
endmodule

// File: tb/tb_async_fifo_lvl.sv
// Scoreboard bench for async_fifo_lvl: directed flag/level scenarios plus a
// randomized dual-clock run checked against a queue model of the FIFO contents.
module tb_async_fifo_lvl;
  localparam int DS = 8;
  localparam int AS = 4;
  localparam int DEPTH = 16;
  localparam int AFULL = 12;
  localparam int AEMPTY = 2;

  // Time unit is 0.1 ns: wclk 10 ns, rclk 27 ns, edges never coincide.
  logic wclk = 1'b0;
  logic rclk = 1'b0;
  logic wrst_n, rrst_n;

  async_fifo_lvl_if #(.DATASIZE(DS), .ADDRSIZE(AS)) bus();

  async_fifo_lvl #(.DATASIZE(DS), .ADDRSIZE(AS)) dut (
    .wclk(wclk), .wrst_n(wrst_n), .rclk(rclk), .rrst_n(rrst_n), .bus(bus)
  );

  initial forever #50 wclk = ~wclk;
  initial begin
    #7;
    forever #135 rclk = ~rclk;
  end

  int checks = 0;
  int errors = 0;
  int wr_acc = 0;
  int rd_acc = 0;
  bit bg_on = 1'b0;
  logic [DS-1:0] model_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Write monitor: every accepted write enters the model.
  always @(posedge wclk) begin
    if (wrst_n && bus.winc && !bus.wfull) begin
      check("write_within_capacity", 32'(model_q.size() < DEPTH), 32'd1);
      model_q.push_back(bus.wdata);
      wr_acc++;
    end
  end

  // Read monitor: every accepted read must return the oldest model entry.
  always @(posedge rclk) begin
    if (rrst_n && bus.rinc && !bus.rempty) begin
      check("read_has_data", 32'(model_q.size() > 0), 32'd1);
      if (model_q.size() > 0) check("rdata_order", 32'(bus.rdata), 32'(model_q.pop_front()));
      rd_acc++;
    end
  end

  // Flag/level relations and occupancy bounds that must hold every cycle.
  always @(negedge wclk) begin
    if (bg_on && wrst_n) begin
      check("wafull_vs_wlevel", 32'(bus.wafull), 32'(bus.wlevel >= 5'(AFULL)));
      check("wfull_vs_wlevel", 32'(bus.wfull), 32'(bus.wlevel == 5'(DEPTH)));
      check("wlevel_le_depth", 32'(bus.wlevel <= 5'(DEPTH)), 32'd1);
      check("wlevel_ge_occupancy", 32'(int'(bus.wlevel) >= model_q.size()), 32'd1);
    end
  end

  always @(negedge rclk) begin
    if (bg_on && rrst_n) begin
      check("rempty_vs_rlevel", 32'(bus.rempty), 32'(bus.rlevel == 5'd0));
      check("raempty_vs_rlevel", 32'(bus.raempty), 32'(bus.rlevel <= 5'(AEMPTY)));
      check("rlevel_le_occupancy", 32'(int'(bus.rlevel) <= model_q.size()), 32'd1);
    end
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
    $fatal(1, "watchdog");
  end

  task automatic write_one(input logic [DS-1:0] d);
    @(negedge wclk);
    bus.winc = 1'b1;
    bus.wdata = d;
    @(negedge wclk);
    bus.winc = 1'b0;
  endtask

  task automatic read_one();
    @(negedge rclk);
    bus.rinc = 1'b1;
    @(negedge rclk);
    bus.rinc = 1'b0;
  endtask

  task automatic settle(input int n);
    repeat (n) @(negedge rclk);
  endtask

  task automatic wait_nonempty(input string name);
    for (int i = 0; i < 8; i++) begin
      @(negedge rclk);
      if (!bus.rempty) break;
    end
    check(name, 32'(bus.rempty), 32'd0);
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_wfull"}, 32'(bus.wfull), 32'd0);
    check({tag, "_wafull"}, 32'(bus.wafull), 32'd0);
    check({tag, "_wlevel"}, 32'(bus.wlevel), 32'd0);
    check({tag, "_woverflow"}, 32'(bus.woverflow), 32'd0);
    check({tag, "_rempty"}, 32'(bus.rempty), 32'd1);
    check({tag, "_raempty"}, 32'(bus.raempty), 32'd1);
    check({tag, "_rlevel"}, 32'(bus.rlevel), 32'd0);
    check({tag, "_runderflow"}, 32'(bus.runderflow), 32'd0);
  endtask

  initial begin
    int wstart, rstart;
    wrst_n = 1'b0;
    rrst_n = 1'b0;
    bus.winc = 1'b0;
    bus.wdata = '0;
    bus.wclr_ovf = 1'b0;
    bus.rinc = 1'b0;
    bus.rclr_unf = 1'b0;
    bus.afull_lvl = 5'(AFULL);
    bus.aempty_lvl = 5'(AEMPTY);

    // 1: reset state
    #200;
    check_reset_state("in_reset");
    @(negedge wclk);
    #23;
    wrst_n = 1'b1;
    rrst_n = 1'b1;
    settle(3);
    check_reset_state("after_reset");
    bg_on = 1'b1;

    // 2: fill to full, overflow, drain in order
    for (int i = 0; i < DEPTH; i++) begin
      write_one(8'(i));
      check("fill_wlevel", 32'(bus.wlevel), 32'(i + 1));
      check("fill_wfull", 32'(bus.wfull), 32'(i == DEPTH - 1));
      check("fill_wafull", 32'(bus.wafull), 32'(i + 1 >= AFULL));
    end
    write_one(8'hAA);
    check("ovf_set", 32'(bus.woverflow), 32'd1);
    check("ovf_wlevel", 32'(bus.wlevel), 32'd16);
    @(negedge wclk) bus.wclr_ovf = 1'b1;
    @(negedge wclk) bus.wclr_ovf = 1'b0;
    check("ovf_clear", 32'(bus.woverflow), 32'd0);
    @(negedge wclk);
    bus.winc = 1'b1;
    bus.wclr_ovf = 1'b1;
    bus.wdata = 8'hBB;
    @(negedge wclk);
    bus.winc = 1'b0;
    bus.wclr_ovf = 1'b0;
    check("ovf_set_wins", 32'(bus.woverflow), 32'd1);
    @(negedge wclk) bus.wclr_ovf = 1'b1;
    @(negedge wclk) bus.wclr_ovf = 1'b0;
    settle(4);
    check("full_rlevel", 32'(bus.rlevel), 32'd16);
    for (int i = 0; i < DEPTH; i++) begin
      read_one();
      check("drain_rlevel", 32'(bus.rlevel), 32'(DEPTH - 1 - i));
    end
    check("drain_rempty", 32'(bus.rempty), 32'd1);
    check("drain_model_empty", 32'(model_q.size()), 32'd0);

    // 3: almost-full and almost-empty thresholds
    settle(4);
    for (int i = 0; i < AFULL; i++) begin
      write_one(8'(8'h20 + i));
      check("afull_wlevel", 32'(bus.wlevel), 32'(i + 1));
      check("afull_wafull", 32'(bus.wafull), 32'(i + 1 >= AFULL));
    end
    settle(4);
    check("afull_rlevel", 32'(bus.rlevel), 32'd12);
    @(negedge rclk) bus.rinc = 1'b1;
    @(posedge rclk);
    fork
      begin
        #10 bus.rinc = 1'b0;
      end
    join_none
    repeat (3) @(posedge wclk);
    #10;
    check("wafull_drop_3_edges", 32'(bus.wafull), 32'd0);
    check("wlevel_after_read", 32'(bus.wlevel), 32'd11);
    @(negedge rclk);
    check("rlevel_after_read", 32'(bus.rlevel), 32'd11);
    for (int k = 11; k >= 1; k--) begin
      read_one();
      check("aempty_rlevel", 32'(bus.rlevel), 32'(k - 1));
      check("aempty_raempty", 32'(bus.raempty), 32'(k - 1 <= AEMPTY));
    end

    // 4: underflow flag, clear, and set-over-clear priority
    @(negedge rclk) bus.rinc = 1'b1;
    @(negedge rclk) bus.rinc = 1'b0;
    check("unf_set", 32'(bus.runderflow), 32'd1);
    check("unf_rlevel", 32'(bus.rlevel), 32'd0);
    check("unf_rempty", 32'(bus.rempty), 32'd1);
    @(negedge rclk) bus.rclr_unf = 1'b1;
    @(negedge rclk) bus.rclr_unf = 1'b0;
    check("unf_clear", 32'(bus.runderflow), 32'd0);
    @(negedge rclk);
    bus.rinc = 1'b1;
    bus.rclr_unf = 1'b1;
    @(negedge rclk);
    bus.rinc = 1'b0;
    bus.rclr_unf = 1'b0;
    check("unf_set_wins", 32'(bus.runderflow), 32'd1);
    @(negedge rclk) bus.rclr_unf = 1'b1;
    @(negedge rclk) bus.rclr_unf = 1'b0;
    check("unf_clear2", 32'(bus.runderflow), 32'd0);
    write_one(8'h3C);
    wait_nonempty("post_unf_nonempty");
    check("post_unf_rdata", 32'(bus.rdata), 32'h3C);
    read_one();

    // 5: random traffic, 200 words through several pointer wraps
    settle(4);
    wstart = wr_acc;
    rstart = rd_acc;
    fork
      begin
        int wguard = 0;
        while (wr_acc < wstart + 200 && wguard < 20000) begin
          @(negedge wclk);
          wguard++;
          if (wr_acc >= wstart + 200) bus.winc = 1'b0;
          else begin
            bus.winc = 1'($urandom_range(0, 1));
            bus.wdata = 8'($urandom);
          end
        end
        bus.winc = 1'b0;
      end
      begin
        int rguard = 0;
        while (rd_acc < rstart + 200 && rguard < 20000) begin
          @(negedge rclk);
          rguard++;
          if (rd_acc >= rstart + 200) bus.rinc = 1'b0;
          else bus.rinc = 1'($urandom_range(0, 1));
        end
        bus.rinc = 1'b0;
      end
    join
    check("rand_writes_done", 32'(wr_acc - wstart), 32'd200);
    check("rand_reads_done", 32'(rd_acc - rstart), 32'd200);
    check("rand_model_empty", 32'(model_q.size()), 32'd0);
    @(negedge wclk) bus.wclr_ovf = 1'b1;
    @(negedge wclk) bus.wclr_ovf = 1'b0;
    @(negedge rclk) bus.rclr_unf = 1'b1;
    @(negedge rclk) bus.rclr_unf = 1'b0;

    // 6: reset mid-traffic, then FIFO restarts from address zero
    settle(4);
    for (int i = 0; i < 9; i++) write_one(8'(8'h60 + i));
    settle(4);
    check("pre_reset_rlevel", 32'(bus.rlevel), 32'd9);
    @(negedge wclk);
    bus.winc = 1'b1;
    bus.wdata = 8'h77;
    bus.rinc = 1'b1;
    repeat (3) @(negedge wclk);
    #23;
    wrst_n = 1'b0;
    rrst_n = 1'b0;
    bus.winc = 1'b0;
    bus.rinc = 1'b0;
    model_q.delete();
    #10;
    check_reset_state("mid_reset");
    @(negedge wclk);
    #23;
    wrst_n = 1'b1;
    rrst_n = 1'b1;
    settle(3);
    write_one(8'h5A);
    wait_nonempty("post_reset_nonempty");
    check("post_reset_rdata", 32'(bus.rdata), 32'h5A);
    read_one();
    settle(2);
    check("post_reset_rempty", 32'(bus.rempty), 32'd1);
    check("post_reset_model_empty", 32'(model_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
